multdiv_sched: RTL

Multi-cycle sequencer for the shared multiply/divide unit in the processor core. It detects R-type MUL/DIV at decode, stalls fetch/decode, pulses the unit's start strobe and waits for its ready flag. It then issues a one-cycle register-file writeback: the product or quotient to `rd`, or the exception code to `$r30` (rstatus). It sits beside the control-signal decoder and owns the register-file write port during MUL/DIV writeback cycles.

---
 rtl/proc_ctrl_pkg.sv | 23 ++
 rtl/multdiv_sched_if.sv | 32 +++
 rtl/md_timeout_counter.sv | 38 +++
 rtl/multdiv_sched.sv | 120 ++++++++++++
 4 files changed

// File: rtl/proc_ctrl_pkg.sv
// Shared control-path constants for the processor core: R-type MUL/DIV decode
// fields, rstatus exception codes and the MUL/DIV sequencer state encoding.
package proc_ctrl_pkg;

  localparam logic [4:0]  OP_RTYPE    = 5'b00000;
  localparam logic [4:0]  ALU_MUL     = 5'b00110;
  localparam logic [4:0]  ALU_DIV     = 5'b00111;
  localparam logic [31:0] RSTATUS_MUL = 32'd4;
  localparam logic [31:0] RSTATUS_DIV = 32'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } md_state_e;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_kind_e;

endpackage

// File: rtl/multdiv_sched_if.sv
// Decode / multdiv-unit / register-file signals seen by the MUL/DIV sequencer.
// master drives decode and unit results; slave is the sequencer itself.
interface multdiv_sched_if;

  logic        issue_valid;
  logic [4:0]  opcode;
  logic [4:0]  alu_op;
  logic [4:0]  rd;
  logic [31:0] md_result;
  logic        md_resultRDY;
  logic        md_exception;

  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        busy;
  logic        timeout_err;

  modport master (
    output issue_valid, opcode, alu_op, rd, md_result, md_resultRDY, md_exception,
    input  ctrl_MULT, ctrl_DIV, stall, wb_en, wb_reg, wb_data, busy, timeout_err
  );

  modport slave (
    input  issue_valid, opcode, alu_op, rd, md_result, md_resultRDY, md_exception,
    output ctrl_MULT, ctrl_DIV, stall, wb_en, wb_reg, wb_data, busy, timeout_err
  );

endinterface

// File: rtl/md_timeout_counter.sv
// Wait-cycle counter for the MUL/DIV sequencer. tc flags the last allowed
// counting cycle, so the increment taking place then reaches TIMEOUT.
module md_timeout_counter #(
  parameter int TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: default first, so every path assigns cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // NOTE: non-blocking for state, so all flops update together on the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = en && (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_sched.sv
// MUL/DIV sequencer: stalls decode, strobes the shared multdiv unit, waits for
// its ready pulse and issues a single register-file writeback (or rstatus code).
module multdiv_sched
  import proc_ctrl_pkg::*;
#(
  parameter int         TIMEOUT     = 40,
  parameter logic [4:0] RSTATUS_REG = 5'd30
) (
  input logic            clock,
  input logic            reset,
  multdiv_sched_if.slave bus
);

  md_state_e   state_q, state_d;
  md_kind_e    kind_q, kind_d;
  logic [4:0]  rd_q, rd_d;
  logic        ctrl_mult_q, ctrl_mult_d;
  logic        ctrl_div_q, ctrl_div_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_reg_q, wb_reg_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        busy_q, busy_d;
  logic        timeout_err_q, timeout_err_d;
  logic        hit, cnt_tc;

  assign hit = bus.issue_valid && (bus.opcode == OP_RTYPE) &&
               ((bus.alu_op == ALU_MUL) || (bus.alu_op == ALU_DIV));

  assign bus.stall = (hit && ((state_q == S_IDLE) || (state_q == S_WB))) ||
                     (state_q == S_START) || (state_q == S_WAIT);

  md_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clock (clock),
    .reset (reset),
    .clr   (state_q == S_START),
    .en    (state_q == S_WAIT),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    rd_d          = rd_q;
    wb_en_d       = 1'b0;
    wb_reg_d      = wb_reg_q;
    wb_data_d     = wb_data_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      S_IDLE, S_WB: begin
        if (hit) begin
          state_d = S_START;
          kind_d  = (bus.alu_op == ALU_DIV) ? MD_DIV : MD_MUL;
          rd_d    = bus.rd;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        // A ready pulse on the final wait cycle still wins over the timeout.
        if (bus.md_resultRDY) begin
          state_d = S_WB;
          if (bus.md_exception) begin
            wb_en_d   = 1'b1;
            wb_reg_d  = RSTATUS_REG;
            wb_data_d = (kind_q == MD_DIV) ? RSTATUS_DIV : RSTATUS_MUL;
          end else if (rd_q != 5'd0) begin
            wb_en_d   = 1'b1;
            wb_reg_d  = rd_q;
            wb_data_d = bus.md_result;
          end
        end else if (cnt_tc) begin
          state_d       = S_IDLE;
          timeout_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ctrl_mult_d = (state_d == S_START) && (kind_d == MD_MUL);
    ctrl_div_d  = (state_d == S_START) && (kind_d == MD_DIV);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      kind_q        <= MD_MUL;
      rd_q          <= '0;
      ctrl_mult_q   <= 1'b0;
      ctrl_div_q    <= 1'b0;
      wb_en_q       <= 1'b0;
      wb_reg_q      <= '0;
      wb_data_q     <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      rd_q          <= rd_d;
      ctrl_mult_q   <= ctrl_mult_d;
      ctrl_div_q    <= ctrl_div_d;
      wb_en_q       <= wb_en_d;
      wb_reg_q      <= wb_reg_d;
      wb_data_q     <= wb_data_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.ctrl_MULT   = ctrl_mult_q;
  assign bus.ctrl_DIV    = ctrl_div_q;
  assign bus.wb_en       = wb_en_q;
  assign bus.wb_reg      = wb_reg_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
